// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: read-side consumer of the async FIFO; pops one word at a time and sends it as a UART frame.
// Optional feature macro FIFO_UART_TX_PARITY_EN adds an even-parity bit between the MSB and the stop bit.
module fifo_uart_tx #(
  parameter int data_width   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  fifo_empty,
  input  logic [data_width-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(data_width + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(data_width - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, WAIT, START, DATA, STOP} state_t;
`endif

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [data_width-1:0] shift_q, shift_d;
  logic                  tx_d;
  logic                  rd_en_d;
  logic                  busy_d;
  logic                  done_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  // All outputs are registered: the next-state logic also computes next output values.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx         <= tx_d;
      fifo_rd_en <= rd_en_d;
      busy       <= busy_d;
      tx_done    <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx;
    rd_en_d = 1'b0;
    done_d  = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          rd_en_d = 1'b1;
          state_d = REQ;
        end
      end

      REQ: begin
        tx_d    = 1'b1;
        state_d = WAIT;
      end

      // FIFO output is registered, so the popped word is only valid one cycle after the pop.
      WAIT: begin
        shift_d = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = ^fifo_data;
`endif
        tx_d    = 1'b0;
        baud_d  = '0;
        bit_d   = '0;
        state_d = START;
      end

      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[data_width-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif

      // tx_done is raised one cycle early so that the registered pulse lands on the last stop cycle.
      STOP: begin
        tx_d = 1'b1;
        if (baud_q == BAUD_PRE) begin
          done_d = 1'b1;
        end
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives fifo_uart_tx from a queue-based FIFO model and checks every cycle
// against a frame-level reference model plus a table of directed words.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB    = 10 + PAR;
  localparam int FRAME = NB * CPB;

  logic          CLK = 1'b0;
  logic          RST_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd_en;
  logic          tx;
  logic          busy;
  logic          tx_done;

  always #5 CLK = ~CLK;

  fifo_uart_tx #(
    .data_width  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  typedef struct {
    logic [7:0] word;
    logic [9:0] line;
    logic       par;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] fifo_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int frame_pos = -1;
  int cur_n = -1;
  int frames_done = 0;
  int obs_rd = 0;
  int obs_done = 0;
  int start_cyc = -1;
  int last_end = -1;
  int last_gap = -1;
  logic [10:0] frame_bits;
  logic [10:0] cap_bits;
  logic [10:0] last_bits;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Reference model: a pop at step k means start bit at step k+2, then NB bits of CPB cycles each.
  task automatic modelCheck(input logic rst_now, input logic empty_now);
    int n;
    if (fifo_rd_en === 1'b1) obs_rd++;
    if (tx_done === 1'b1) obs_done++;
    cur_n = -1;
    if (rst_now !== 1'b1) begin
      checkOutput("rst_tx", tx, 1);
      checkOutput("rst_rd_en", fifo_rd_en, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", tx_done, 0);
      frame_pos = -1;
      last_end  = -1;
      return;
    end
    if (frame_pos < 0) begin
      if (fifo_rd_en !== 1'b1) begin
        checkOutput("idle_rd_en", fifo_rd_en, 0);
        checkOutput("idle_tx", tx, 1);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_done", tx_done, 0);
        return;
      end
      checkOutput("rd_en_while_empty", empty_now, 0);
      checkOutput("rd_en_word_avail", (fifo_q.size() > 0) ? 1 : 0, 1);
      frame_bits    = '1;
      frame_bits[0] = 1'b0;
      if (fifo_q.size() > 0) begin
        frame_bits[8:1] = fifo_q[0];
        if (PAR == 1) frame_bits[9] = ^fifo_q[0];
      end
      cap_bits  = '1;
      frame_pos = 0;
    end
    checkOutput("frame_rd_en", fifo_rd_en, (frame_pos == 0) ? 1 : 0);
    checkOutput("frame_busy", busy, 1);
    if (frame_pos < 2) begin
      checkOutput("frame_pre_tx", tx, 1);
      checkOutput("frame_pre_done", tx_done, 0);
      frame_pos++;
    end else begin
      n = frame_pos - 2;
      cur_n = n;
      if (n == 0) begin
        start_cyc = cyc;
        if (last_end >= 0) last_gap = cyc - last_end - 1;
      end
      checkOutput("frame_tx", tx, frame_bits[n / CPB]);
      if (n % CPB == CPB / 2) cap_bits[n / CPB] = tx;
      checkOutput("frame_done", tx_done, (n == FRAME - 1) ? 1 : 0);
      if (n == FRAME - 1) begin
        frame_pos = -1;
        frames_done++;
        last_end  = cyc;
        last_bits = cap_bits;
      end else begin
        frame_pos++;
      end
    end
  endtask

  // One clock: the FIFO pops on the edge that sees rd_en, data is scrambled whenever it is not valid.
  task automatic step();
    logic pop_now, rst_now, empty_now;
    pop_now   = (fifo_rd_en === 1'b1);
    rst_now   = RST_n;
    empty_now = fifo_empty;
    @(posedge CLK);
    #1;
    cyc++;
    if (pop_now && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    else fifo_data = 8'($urandom);
    fifo_empty = (fifo_q.size() == 0);
    modelCheck(rst_now, empty_now);
  endtask

  task automatic applyStimulus(input logic [7:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic waitFrames(input int target, input int budget);
    int k = 0;
    while (frames_done < target && k < budget) begin
      step();
      k++;
    end
    checkOutput("frame_timeout", frames_done, target);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rd0, dn0, f0, rel, nw, k, cnt;
    logic [10:0] exp11;
    logic [9:0]  line99;

    vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
    vecs[1] = '{8'h3C, 10'b1_00111100_0, 1'b0};
    vecs[2] = '{8'h07, 10'b1_00000111_0, 1'b1};
    vecs[3] = '{8'h80, 10'b1_10000000_0, 1'b1};
    vecs[4] = '{8'h01, 10'b1_00000001_0, 1'b1};
    vecs[5] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    vecs[6] = '{8'h00, 10'b1_00000000_0, 1'b0};
    vecs[7] = '{8'h6E, 10'b1_01101110_0, 1'b1};

    RST_n      = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    $display("[TB] reset with a non-empty FIFO");
    applyStimulus(8'h5A);
    step();
    step();
    checkOutput("reset_rd_count", obs_rd, 0);
    RST_n = 1'b1;
    waitFrames(1, 4 * FRAME);

    $display("[TB] directed word table");
    for (int i = 0; i < 8; i++) begin
      rd0 = obs_rd;
      dn0 = obs_done;
      f0  = frames_done;
      applyStimulus(vecs[i].word);
      waitFrames(f0 + 1, 4 * FRAME);
      exp11 = (PAR == 1) ? {1'b1, vecs[i].par, vecs[i].line[8:0]} : {1'b1, vecs[i].line};
      checkOutput("vec_line", last_bits, exp11);
      checkOutput("vec_rd_pulses", obs_rd - rd0, 1);
      checkOutput("vec_done_pulses", obs_done - dn0, 1);
      repeat (5) step();
    end

    $display("[TB] back-to-back words");
    rd0 = obs_rd;
    dn0 = obs_done;
    f0  = frames_done;
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    waitFrames(f0 + 2, 6 * FRAME);
    checkOutput("b2b_gap", last_gap, 3);
    checkOutput("b2b_rd_pulses", obs_rd - rd0, 2);
    checkOutput("b2b_done_pulses", obs_done - dn0, 2);

    $display("[TB] empty FIFO idle");
    rd0 = obs_rd;
    repeat (100) step();
    checkOutput("empty_rd_count", obs_rd - rd0, 0);

    $display("[TB] reset during data bit 3");
    applyStimulus(8'h3C);
    k = 0;
    while (cur_n != 4 * CPB + 1 && k < 4 * FRAME) begin
      step();
      k++;
    end
    checkOutput("reach_bit3", cur_n, 4 * CPB + 1);
    RST_n = 1'b0;
    applyStimulus(8'h99);
    rd0 = obs_rd;
    step();
    checkOutput("rst_mid_tx", tx, 1);
    checkOutput("rst_mid_busy", busy, 0);
    step();
    checkOutput("rst_low_rd_count", obs_rd - rd0, 0);
    RST_n = 1'b1;
    rel = cyc;
    f0  = frames_done;
    waitFrames(f0 + 1, 4 * FRAME);
    checkOutput("rst_restart_edge", start_cyc, rel + 3);
    line99 = 10'b1_10011001_0;
    exp11  = (PAR == 1) ? {1'b1, 1'b0, line99[8:0]} : {1'b1, line99};
    checkOutput("rst_next_word", last_bits, exp11);

    $display("[TB] randomized traffic");
    rd0 = obs_rd;
    dn0 = obs_done;
    f0  = frames_done;
    nw  = 0;
    for (int it = 0; it < 30; it++) begin
      cnt = $urandom_range(1, 3);
      for (int j = 0; j < cnt; j++) begin
        applyStimulus(8'($urandom));
        nw++;
      end
      repeat ($urandom_range(0, 60)) step();
    end
    waitFrames(f0 + nw, nw * (FRAME + 10) + 100);
    checkOutput("rand_rd_pulses", obs_rd - rd0, nw);
    checkOutput("rand_done_pulses", obs_done - dn0, nw);
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
